i2c_slave_rx_ctrl: RTL

//  Byte-level controller for the I2C slave receive path. Consumes SCL edge and

---
 rtl/i2c_slave_rx_ctrl_pkg.sv | 31 +++
 rtl/i2c_slave_rx_ctrl_if.sv | 30 +++
 rtl/i2c_slave_rx_ctrl_bit_counter.sv | 36 +++
 rtl/i2c_slave_rx_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/i2c_slave_rx_ctrl_pkg.sv
// Purpose: shared types and constants for the I2C slave byte controllers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_CHK,
    ACK,
    DATA,
    DATA_CHK,
    WAIT_STOP
  } i2c_rx_state_t;

  localparam int   I2C_BYTE_BITS = 8;
  localparam logic I2C_RW_READ   = 1'b1;
  localparam int   I2C_CNT_W     = 4;

  // bit_cnt value seen on the rising edge that clocks in the last data bit
  localparam logic [I2C_CNT_W-1:0] I2C_CNT_LAST = I2C_CNT_W'(I2C_BYTE_BITS - 1);
  // bit_cnt value once the 9th (ACK) rising edge has been seen
  localparam logic [I2C_CNT_W-1:0] I2C_CNT_ACK  = I2C_CNT_W'(I2C_BYTE_BITS + 1);

  // Address byte layout: [7:1] = 7-bit address, [0] = R/W
  function automatic logic i2c_addr_match(input logic [7:0] byte_in,
                                          input logic [6:0] addr);
    return byte_in[7:1] == addr;
  endfunction

endpackage

// File: rtl/i2c_slave_rx_ctrl_if.sv
// Purpose: bundle between bus synchroniser/shift register/FIFO and the RX controller.
// Latency: n/a (wires only).
// Backpressure: rx_full from the FIFO side; the controller NACKs rather than stalls.
//   slave  : controller view (strobes and rx_data in, enables and strobes out)
//   master : environment view (drives strobes/rx_data/rx_full, observes outputs)
interface i2c_slave_rx_ctrl_if;
  logic       rising_edge;
  logic       falling_edge;
  logic       start_found;
  logic       stop_found;
  logic [7:0] rx_data;
  logic       rx_full;
  logic       rx_enable;
  logic       sda_pull_low;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       read_start;
  logic       overflow;
  logic       busy;

  modport slave (
    input  rising_edge, falling_edge, start_found, stop_found, rx_data, rx_full,
    output rx_enable, sda_pull_low, byte_valid, byte_data, read_start, overflow, busy
  );

  modport master (
    output rising_edge, falling_edge, start_found, stop_found, rx_data, rx_full,
    input  rx_enable, sda_pull_low, byte_valid, byte_data, read_start, overflow, busy
  );
endinterface

// File: rtl/i2c_slave_rx_ctrl_bit_counter.sv
// Purpose: small bit counter with clear/increment and a "done" compare, shared by RX/TX.
// Latency: count updates 1 clk after clr_i/inc_i; done_o is a decode of the register.
// Backpressure: none; the owner decides when to increment.
//   clk, rst : clock, synchronous active-high reset
//   clr_i    : clear to 0 (wins over inc_i)
//   inc_i    : increment by 1
//   cnt_o    : current count
//   done_o   : 1 when cnt_o == DONE_AT
module i2c_bit_counter
  import i2c_pkg::*;
#(
  parameter int W       = I2C_CNT_W,
  parameter int DONE_AT = I2C_BYTE_BITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o  = cnt_q;
  assign done_o = (cnt_q == W'(DONE_AT));

endmodule

// File: rtl/i2c_slave_rx_ctrl.sv
// Purpose: I2C slave receive byte controller (address check, ACK/NACK, write-byte hand-off).
// Latency: byte_valid/read_start/overflow 1 clk after the falling edge following bit 8.
// Backpressure: rx_full at the data check NACKs the byte and parks until STOP/START.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave modport -- SCL edge / START / STOP strobes, rx_data, rx_full in;
//              rx_enable, sda_pull_low, byte_valid, byte_data, read_start, overflow, busy out
module i2c_slave_rx_ctrl
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h38
) (
  input  logic                 clk,
  input  logic                 rst,
  i2c_slave_rx_ctrl_if.slave   bus
);

  i2c_rx_state_t        state_q;
  i2c_rx_state_t        ack_next_q;   // where to go once the ACK bit is over
  logic                 rx_enable_q;
  logic                 sda_pull_low_q;
  logic                 byte_valid_q;
  logic [7:0]           byte_data_q;
  logic                 read_start_q;
  logic                 overflow_q;
  logic                 busy_q;

  logic [I2C_CNT_W-1:0] cnt;
  logic                 cnt_done;
  logic                 cnt_clr;
  logic                 cnt_inc;
  logic                 bus_event;    // START/STOP this cycle: edge strobes are ignored
  logic                 ack_release;
  logic                 shifting;

  assign bus_event   = bus.stop_found | bus.start_found;
  assign shifting    = (state_q == ADDR) || (state_q == DATA);
  assign ack_release = !bus_event && (state_q == ACK) && bus.falling_edge &&
                       (cnt == I2C_CNT_ACK);

  // In ACK the counter only steps 8 -> 9 so the release is tied to the first
  // rising edge seen after the ACK was driven.
  assign cnt_clr = bus_event | ack_release;
  assign cnt_inc = !bus_event && bus.rising_edge &&
                   (shifting || ((state_q == ACK) && cnt_done));

  i2c_bit_counter #(
    .W       (I2C_CNT_W),
    .DONE_AT (I2C_BYTE_BITS)
  ) u_bit_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .cnt_o  (cnt),
    .done_o (cnt_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      ack_next_q     <= IDLE;
      rx_enable_q    <= 1'b0;
      sda_pull_low_q <= 1'b0;
      byte_valid_q   <= 1'b0;
      byte_data_q    <= 8'h00;
      read_start_q   <= 1'b0;
      overflow_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      read_start_q <= 1'b0;
      overflow_q   <= 1'b0;

      if (bus.stop_found) begin
        state_q        <= IDLE;
        rx_enable_q    <= 1'b0;
        sda_pull_low_q <= 1'b0;
        busy_q         <= 1'b0;
      end else if (bus.start_found) begin
        state_q        <= ADDR;
        rx_enable_q    <= 1'b1;
        sda_pull_low_q <= 1'b0;
        busy_q         <= 1'b1;
      end else begin
        case (state_q)
          ADDR, DATA: begin
            if (bus.rising_edge && (cnt == I2C_CNT_LAST)) begin
              rx_enable_q <= 1'b0;
              state_q     <= (state_q == ADDR) ? ADDR_CHK : DATA_CHK;
            end
          end

          // The shift register settles one clk after the 8th rising edge, so
          // rx_data is safe to use at the next falling edge.
          ADDR_CHK: begin
            if (bus.falling_edge && cnt_done) begin
              if (i2c_addr_match(bus.rx_data, SLAVE_ADDR)) begin
                sda_pull_low_q <= 1'b1;
                state_q        <= ACK;
                if (bus.rx_data[0] == I2C_RW_READ) begin
                  read_start_q <= 1'b1;
                  ack_next_q   <= WAIT_STOP;
                end else begin
                  ack_next_q   <= DATA;
                end
              end else begin
                state_q <= WAIT_STOP;
              end
            end
          end

          DATA_CHK: begin
            if (bus.falling_edge && cnt_done) begin
              if (!bus.rx_full) begin
                byte_data_q    <= bus.rx_data;
                byte_valid_q   <= 1'b1;
                sda_pull_low_q <= 1'b1;
                ack_next_q     <= DATA;
                state_q        <= ACK;
              end else begin
                overflow_q <= 1'b1;
                state_q    <= WAIT_STOP;
              end
            end
          end

          ACK: begin
            if (ack_release) begin
              sda_pull_low_q <= 1'b0;
              state_q        <= ack_next_q;
              rx_enable_q    <= (ack_next_q == DATA);
            end
          end

          default: begin
            // IDLE and WAIT_STOP ignore SCL activity
          end
        endcase
      end
    end
  end

  assign bus.rx_enable    = rx_enable_q;
  assign bus.sda_pull_low = sda_pull_low_q;
  assign bus.byte_valid   = byte_valid_q;
  assign bus.byte_data    = byte_data_q;
  assign bus.read_start   = read_start_q;
  assign bus.overflow     = overflow_q;
  assign bus.busy         = busy_q;

endmodule
